// File: rtl/regfile_32x32_pkg.sv
//------------------------------------------------------------------------------
// regfile_32x32_pkg : shared sizes and types for the 32-entry register file
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_32x32_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_sel_t;

endpackage : regfile_32x32_pkg

`default_nettype wire

// File: rtl/regfile_32x32_if.sv
//------------------------------------------------------------------------------
// regfile_32x32_if : write port and two read ports of the register file
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_32x32_if #(
  parameter int DATA_WIDTH = 32
);
  import regfile_32x32_pkg::*;

  logic                  ctrl_writeEnable;
  reg_addr_t             ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  reg_addr_t             ctrl_readRegA;
  reg_addr_t             ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );

endinterface : regfile_32x32_if

`default_nettype wire

// File: rtl/decoder_5_32.sv
//------------------------------------------------------------------------------
// decoder_5_32 : 5-bit binary address to 32-bit one-hot select
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decoder_5_32 (
  input  wire logic [4:0]  i_addr,
  output      logic [31:0] o_sel
);

  assign o_sel = 32'd1 << i_addr;

endmodule : decoder_5_32

`default_nettype wire

// File: rtl/regfile_32x32.sv
//------------------------------------------------------------------------------
// regfile_32x32 : 32 x DATA_WIDTH register file, 1 write / 2 async read ports,
//                 r0 hard-wired to zero, optional write-to-read bypass
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS     = 1'b0
) (
  input  wire logic      clock,
  input  wire logic      ctrl_reset_n,
  regfile_32x32_if.slave bus
);

  reg_sel_t              w_sel;
  reg_sel_t              w_we;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic                  w_byp_a;
  logic                  w_byp_b;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  decoder_5_32 u_wr_dec (
    .i_addr (bus.ctrl_writeReg),
    .o_sel  (w_sel)
  );

  assign w_we = w_sel & {NUM_REGS{bus.ctrl_writeEnable}};

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == ZERO_REG) begin : g_zero
      // r0 has no storage; its decoded enable is deliberately dropped
      logic w_unused_we;
      assign w_unused_we = w_we[gi];
      assign w_regs[gi]  = '0;
    end else begin : g_flop
      logic [DATA_WIDTH-1:0] r_q;
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
          r_q <= '0;
        end else if (w_we[gi]) begin
          r_q <= bus.data_writeReg;
        end
      end
      assign w_regs[gi] = r_q;
    end
  end

  assign w_byp_a = bus.ctrl_writeEnable && (bus.ctrl_writeReg != reg_addr_t'(ZERO_REG))
                   && (bus.ctrl_writeReg == bus.ctrl_readRegA);
  assign w_byp_b = bus.ctrl_writeEnable && (bus.ctrl_writeReg != reg_addr_t'(ZERO_REG))
                   && (bus.ctrl_writeReg == bus.ctrl_readRegB);

  // Reset gating also suppresses the bypass path, which bypasses the flops
  always_comb begin
    w_rd_a = w_regs[bus.ctrl_readRegA];
    w_rd_b = w_regs[bus.ctrl_readRegB];
    if (BYPASS && w_byp_a) w_rd_a = bus.data_writeReg;
    if (BYPASS && w_byp_b) w_rd_b = bus.data_writeReg;
    if (!ctrl_reset_n) begin
      w_rd_a = '0;
      w_rd_b = '0;
    end
  end

  assign bus.data_readRegA = w_rd_a;
  assign bus.data_readRegB = w_rd_b;

endmodule : regfile_32x32

`default_nettype wire

// File: doc/regfile_32x32.md
REGFILE_32X32 -- requirements
Module: regfile_32x32

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 Parameter BYPASS, default 0; 1 means same-cycle write data is forwarded to the read ports.
REQ-003 clock  input  1  single clock, rising-edge active.
REQ-004 ctrl_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 ctrl_writeEnable  input  1  write strobe, sampled at the rising edge.
REQ-006 ctrl_writeReg  input  5  write address.
REQ-007 data_writeReg  input  DATA_WIDTH  write data.
REQ-008 ctrl_readRegA  input  5  read port A address.
REQ-009 ctrl_readRegB  input  5  read port B address.
REQ-010 data_readRegA  output  DATA_WIDTH  read port A data.
REQ-011 data_readRegB  output  DATA_WIDTH  read port B data.
REQ-012 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-013 The block SHALL hold 32 registers of DATA_WIDTH bits, r0..r31.
REQ-014 ctrl_writeReg SHALL be decoded to a one-hot 32-bit write-select vector, and that vector SHALL be ANDed with ctrl_writeEnable.
REQ-015 On a rising edge with ctrl_writeEnable=1 and ctrl_writeReg!=0, the addressed register SHALL load data_writeReg; all other registers SHALL hold.
REQ-016 r0 SHALL read as all-zeros at all times; writes to address 0 SHALL be ignored.
REQ-017 Read ports SHALL be combinational (zero-cycle latency) from the register array, indexed by ctrl_readRegA and ctrl_readRegB independently.
REQ-018 Both ports reading the same address SHALL return identical data.
REQ-019 Read-during-write with BYPASS=0: a read of the address being written SHALL return the old value until the edge and the new value afterwards.
REQ-020 Read-during-write with BYPASS=1: a read of the address being written, with enable=1 and address!=0, SHALL return data_writeReg in the same cycle.
REQ-021 With ctrl_writeEnable=0, no register SHALL change regardless of ctrl_writeReg or data_writeReg.
REQ-022 X or Z on unused write data SHALL NOT propagate when ctrl_writeEnable=0.
REQ-023 Back-to-back writes to the same address SHALL retain the last-written value.

Reset
REQ-024 Asserting ctrl_reset_n=0 SHALL clear r1..r31 to zero immediately, with no wait for a clock edge.
REQ-025 While ctrl_reset_n=0, writes SHALL be blocked and both read ports SHALL return zero.
REQ-026 Reset asserted mid-write (same cycle as an enabled write) SHALL win; the register SHALL be zero after release.
REQ-027 The first write SHALL take effect on the first rising edge after ctrl_reset_n deasserts.

Structure
REQ-028 A shared package SHALL hold NUM_REGS=32, REG_ADDR_W=5, and the zero-register index ZERO_REG=0.
REQ-029 The write-select decode SHALL be one instance of the team's existing 5-to-32 decoder, decoder_5_32.
REQ-030 The read multiplexers and the register array SHALL be inline in regfile_32x32.
REQ-031 Each register SHALL be a DATA_WIDTH-wide flop bank with per-register enable.

Verification
REQ-032 Reset then read-all: ctrl_reset_n 0->1, sweep readRegA/B over 0..31 -> every read is 0x00000000.
REQ-033 Write/read sweep: write addr k with data 0xA5A50000+k for k=1..31, then read both ports -> each returns 0xA5A50000+k; r0 returns 0.
REQ-034 Zero-register: write 0xFFFFFFFF to addr 0 -> readRegA=0 returns 0x00000000.
REQ-035 Read-during-write: write 0x12345678 to r7 while readRegA=7 -> with BYPASS=0, old value before the edge and 0x12345678 after; with BYPASS=1, 0x12345678 in the same cycle.
REQ-036 Async reset mid-operation: r5=0xDEADBEEF, then drop ctrl_reset_n between edges -> data_readRegA (addr 5) reads 0 before the next edge and stays 0 after release.
REQ-037 Enable-low hold: ctrl_writeEnable=0, ctrl_writeReg=3, data=0xCAFEF00D for 4 cycles -> r3 unchanged.
